// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core with valid/ready handshakes and per-frame error flags.
// Optional macro UART_LOOPBACK_EN adds a loopback input that routes the TX line into the RX synchroniser.
module uart_core_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef UART_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_serial,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int PAR_BITS = (PARITY_MODE != 0) ? 1 : 0;
    localparam int N_BITS   = 1 + DATA_WIDTH + PAR_BITS + STOP_BITS;
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = $clog2(N_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t              tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]      tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_line_q, tx_line_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_last_clk;

    rx_state_t              rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]      rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   rx_ferr_acc_q, rx_ferr_acc_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_in, rxs, rx_sample, rx_stop_err;

`ifdef UART_LOOPBACK_EN
    assign rx_in     = loopback ? tx_line_q : rx_serial;
    assign tx_serial = loopback ? 1'b1 : tx_line_q;
`else
    assign rx_in     = rx_serial;
    assign tx_serial = tx_line_q;
`endif

    assign tx_last_clk = (tx_baud_q == BAUD_LAST);
    assign tx_ready    = (tx_state_q == TX_IDLE) ||
                         (tx_state_q == TX_STOP && tx_bit_q == STOP_LAST && tx_last_clk);
    assign tx_busy     = tx_busy_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        if (tx_state_q != TX_IDLE) begin
            tx_baud_d = tx_last_clk ? '0 : tx_baud_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: ;
            TX_START: begin
                if (tx_last_clk) begin
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_shift_q[0];
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_last_clk) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (PAR_BITS != 0) begin
                            tx_state_d = TX_PARITY;
                            tx_line_d  = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_last_clk) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                    tx_bit_d   = '0;
                end
            end
            TX_STOP: begin
                if (tx_last_clk) begin
                    tx_line_d = 1'b1;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_busy_d  = 1'b0;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // A handshake in the last stop clock overrides the return to idle for gapless frames.
        if (tx_valid && tx_ready) begin
            tx_state_d = TX_START;
            tx_baud_d  = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = (^tx_data) ^ PAR_ODD;
            tx_line_d  = 1'b0;
            tx_busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
    assign rxs         = sync_q[SYNC_STAGES-1];
    assign rx_sample   = (rx_baud_q == BAUD_LAST);
    assign rx_stop_err = rx_ferr_acc_q | ~rxs;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_baud_d     = rx_baud_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_par_d      = rx_par_q;
        rx_ferr_acc_d = rx_ferr_acc_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_d     = 1'b0;
        rx_ferr_d     = 1'b0;
        if (rx_state_q == RX_DATA || rx_state_q == RX_PARITY || rx_state_q == RX_STOP) begin
            rx_baud_d = rx_sample ? '0 : rx_baud_q + 1'b1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                // The detection cycle counts as the first start-bit clock.
                if (!rxs) begin
                    rx_state_d    = RX_START;
                    rx_baud_d     = BAUD_W'(1);
                    rx_bit_d      = '0;
                    rx_ferr_acc_d = 1'b0;
                end
            end
            RX_START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rxs, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = (PAR_BITS != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_d   = rxs;
                    rx_bit_d   = '0;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    if (rx_bit_q == STOP_LAST) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_ferr_d  = rx_stop_err;
                        rx_perr_d  = (PAR_BITS != 0) && ((^rx_shift_q) ^ rx_par_q ^ PAR_ODD);
                        rx_state_d = rx_stop_err ? RX_WAIT_HIGH : RX_IDLE;
                    end else begin
                        rx_bit_d      = rx_bit_q + 1'b1;
                        rx_ferr_acc_d = rx_stop_err;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxs) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '1;
            rx_state_q    <= RX_IDLE;
            rx_baud_q     <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_q      <= 1'b0;
            rx_ferr_acc_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_state_q    <= rx_state_d;
            rx_baud_q     <= rx_baud_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            rx_ferr_acc_q <= rx_ferr_acc_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: default instance (8E1) plus an 8O2 instance looped back on itself.
module tb_uart_core_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid, tx_ready, tx_busy, tx_serial, rx_serial;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err;
    logic       loop_sel, rx_drive;

    logic       tx_valid_b, tx_ready_b, tx_busy_b, tx_serial_b;
    logic [7:0] tx_data_b, rx_data_b;
    logic       rx_valid_b, rx_parity_err_b, rx_frame_err_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int flag_leaks = 0;

    int         rx_cyc_q[$];
    logic [7:0] rx_data_q[$];
    logic       rx_perr_q[$];
    logic       rx_ferr_q[$];
    int         rx_b_cyc_q[$];
    logic [7:0] rx_b_data_q[$];
    logic [1:0] rx_b_err_q[$];

    assign rx_serial = loop_sel ? tx_serial : rx_drive;

    uart_core_param dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_serial(tx_serial), .rx_serial(rx_serial),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
    );

    uart_core_param #(.PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
        .tx_busy(tx_busy_b), .tx_serial(tx_serial_b), .rx_serial(tx_serial_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every received word; error flags must never be set without rx_valid.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cyc_q.push_back(cyc);
            rx_data_q.push_back(rx_data);
            rx_perr_q.push_back(rx_parity_err);
            rx_ferr_q.push_back(rx_frame_err);
        end
        if (rx_valid_b) begin
            rx_b_cyc_q.push_back(cyc);
            rx_b_data_q.push_back(rx_data_b);
            rx_b_err_q.push_back({rx_parity_err_b, rx_frame_err_b});
        end
        if ((!rx_valid && (rx_parity_err || rx_frame_err)) ||
            (!rx_valid_b && (rx_parity_err_b || rx_frame_err_b)))
            flag_leaks <= flag_leaks + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rxCycAt(input int idx);
        return (idx < rx_cyc_q.size()) ? rx_cyc_q[idx] : -1;
    endfunction

    function automatic logic [9:0] rxWordAt(input int idx);
        return (idx < rx_cyc_q.size()) ? {rx_perr_q[idx], rx_ferr_q[idx], rx_data_q[idx]} : 10'h3ff;
    endfunction

    function automatic logic [10:0] makeFrame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic sendWord(input bit use_b, input logic [7:0] d, output int t_start);
        @(negedge clk);
        if (use_b) begin tx_valid_b = 1'b1; tx_data_b = d; end
        else begin tx_valid = 1'b1; tx_data = d; end
        @(posedge clk);
        #1;
        t_start = cyc;
        tx_valid = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic captureFrame(input bit use_b, input int nbits, output logic [15:0] bits,
                                output int busy_cnt, output int ready_cnt);
        logic ser, busy, rdy;
        bits = '0;
        busy_cnt = 0;
        ready_cnt = 0;
        for (int i = 0; i < nbits * 16 + 8; i++) begin
            @(negedge clk);
            ser  = use_b ? tx_serial_b : tx_serial;
            busy = use_b ? tx_busy_b : tx_busy;
            rdy  = use_b ? tx_ready_b : tx_ready;
            if (i % 16 == 8) bits[i / 16] = ser;
            if (busy) busy_cnt++;
            if (rdy && i < nbits * 16) ready_cnt++;
        end
    endtask

    task automatic waitRx(input bit use_b, input int target, input int budget, input string tag);
        int n;
        n = use_b ? rx_b_cyc_q.size() : rx_cyc_q.size();
        for (int i = 0; i < budget && n < target; i++) begin
            @(posedge clk);
            #1;
            n = use_b ? rx_b_cyc_q.size() : rx_cyc_q.size();
        end
        checkOutput(tag, (n >= target), 1);
    endtask

    task automatic applyStimulus(input logic [11:0] bits, input int nbits, output int e_cyc);
        @(posedge clk);
        #1;
        e_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx_drive = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0, t1, t2, e0, base, ready_cyc, busy_cnt, ready_cnt;
        logic [15:0] bits;

        reset = 1'b1;
        tx_valid = 1'b0; tx_data = '0;
        tx_valid_b = 1'b0; tx_data_b = '0;
        loop_sel = 1'b1; rx_drive = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_tx_serial", tx_serial, 1);
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_rx_perr", rx_parity_err, 0);
        checkOutput("rst_rx_ferr", rx_frame_err, 0);

        $display("[TB] 0xA5 loopback, 8E1");
        sendWord(0, 8'hA5, t0);
        captureFrame(0, 11, bits, busy_cnt, ready_cnt);
        checkOutput("a5_frame_bits", bits, 16'b101_0100_1010);
        checkOutput("a5_busy_cycles", busy_cnt, 176);
        checkOutput("a5_ready_cycles", ready_cnt, 1);
        waitRx(0, 1, 400, "a5_rx_arrive");
        checkOutput("a5_rx_latency", rxCycAt(0) - t0, 171);
        checkOutput("a5_rx_word", rxWordAt(0), {2'b00, 8'hA5});

        $display("[TB] 0x00 loopback, 8O2");
        sendWord(1, 8'h00, t0);
        captureFrame(1, 12, bits, busy_cnt, ready_cnt);
        checkOutput("odd_frame_bits", bits, 16'hE00);
        checkOutput("odd_busy_cycles", busy_cnt, 192);
        checkOutput("odd_ready_cycles", ready_cnt, 1);
        waitRx(1, 1, 400, "odd_rx_arrive");
        checkOutput("odd_rx_latency", (rx_b_cyc_q.size() > 0) ? rx_b_cyc_q[0] - t0 : -1, 187);
        checkOutput("odd_rx_data", (rx_b_cyc_q.size() > 0) ? rx_b_data_q[0] : 8'hxx, 8'h00);
        checkOutput("odd_rx_errs", (rx_b_cyc_q.size() > 0) ? rx_b_err_q[0] : 2'bxx, 2'b00);

        $display("[TB] back-to-back 0x55, 0x3C");
        base = rx_cyc_q.size();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h55;
        @(posedge clk);
        #1;
        t1 = cyc;
        tx_data = 8'h3C;
        ready_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready) begin ready_cyc = cyc; break; end
        end
        checkOutput("b2b_ready_cycle", ready_cyc - t1, 175);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        t2 = cyc;
        checkOutput("b2b_frame_spacing", t2 - t1, 176);
        @(negedge clk);
        checkOutput("b2b_second_start", tx_serial, 0);
        checkOutput("b2b_busy_held", tx_busy, 1);
        waitRx(0, base + 2, 500, "b2b_rx_arrive");
        checkOutput("b2b_rx_first", rxWordAt(base), {2'b00, 8'h55});
        checkOutput("b2b_rx_second", rxWordAt(base + 1), {2'b00, 8'h3C});
        checkOutput("b2b_rx_spacing", rxCycAt(base + 1) - rxCycAt(base), 176);

        $display("[TB] directed rx frames: parity error, frame error, break");
        repeat (20) @(posedge clk);
        rx_drive = 1'b1;
        loop_sel = 1'b0;
        repeat (20) @(posedge clk);
        base = rx_cyc_q.size();
        applyStimulus({1'b1, makeFrame(8'hA5, 1'b1, 1'b1)}, 11, e0);
        waitRx(0, base + 1, 100, "perr_rx_arrive");
        checkOutput("perr_rx_latency", rxCycAt(base) - e0, 171);
        checkOutput("perr_rx_word", rxWordAt(base), {2'b10, 8'hA5});
        applyStimulus({1'b0, makeFrame(8'hA5, 1'b0, 1'b0)}, 11, e0);
        waitRx(0, base + 2, 100, "ferr_rx_arrive");
        checkOutput("ferr_rx_word", rxWordAt(base + 1), {2'b01, 8'hA5});
        repeat (500) @(posedge clk);
        checkOutput("break_low_no_extra", rx_cyc_q.size(), base + 2);
        rx_drive = 1'b1;
        repeat (40) @(posedge clk);
        checkOutput("break_high_no_extra", rx_cyc_q.size(), base + 2);
        applyStimulus({1'b1, makeFrame(8'h3C, 1'b0, 1'b1)}, 11, e0);
        waitRx(0, base + 3, 100, "rearm_rx_arrive");
        checkOutput("rearm_rx_word", rxWordAt(base + 2), {2'b00, 8'h3C});

        $display("[TB] 4-cycle glitch on idle line");
        repeat (20) @(posedge clk);
        base = rx_cyc_q.size();
        #1;
        rx_drive = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drive = 1'b1;
        repeat (100) @(posedge clk);
        checkOutput("glitch_no_rx", rx_cyc_q.size(), base);
        applyStimulus({1'b1, makeFrame(8'h5A, 1'b0, 1'b1)}, 11, e0);
        waitRx(0, base + 1, 100, "glitch_after_arrive");
        checkOutput("glitch_after_latency", rxCycAt(base) - e0, 171);
        checkOutput("glitch_after_word", rxWordAt(base), {2'b00, 8'h5A});

        $display("[TB] reset mid TX frame");
        loop_sel = 1'b1;
        repeat (20) @(posedge clk);
        base = rx_cyc_q.size();
        sendWord(0, 8'hA5, t0);
        for (int i = 0; i < 100 && cyc < t0 + 59; i++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_tx_serial", tx_serial, 1);
        checkOutput("midrst_tx_ready", tx_ready, 1);
        checkOutput("midrst_tx_busy", tx_busy, 0);
        checkOutput("midrst_rx_valid", rx_valid, 0);
        @(negedge clk) reset = 1'b0;
        repeat (300) @(posedge clk);
        checkOutput("midrst_no_rx", rx_cyc_q.size(), base);
        checkOutput("midrst_tx_idle", tx_busy, 0);

        checkOutput("flags_without_valid", flag_leaks, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core: transmitter and receiver with valid/ready handshakes.
- Supports configurable data width, parity mode, stop-bit count and clocks-per-bit, plus per-frame error reporting.
- Successor to the fixed 8-bit, even-parity UART; this is the instance the loopback/formal harnesses and system top-levels will use.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9; sent LSB first.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 4.
- SYNC_STAGES, 3, rx_serial synchroniser depth; >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- tx_valid  in  1  transmit request
- tx_data  in  DATA_WIDTH  word to send; sampled on handshake
- tx_ready  out  1  core can accept tx_data this cycle
- tx_busy  out  1  frame in flight on tx_serial
- tx_serial  out  1  serial line, idle high
- rx_serial  in  1  asynchronous serial input
- rx_data  out  DATA_WIDTH  last received word
- rx_valid  out  1  one-cycle pulse, new word
- rx_parity_err  out  1  qualifies rx_valid: parity mismatch
- rx_frame_err  out  1  qualifies rx_valid: a stop bit sampled low

Behaviour:
- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_data=0. Synchroniser flops reset to 1.
- Reset mid-frame: both FSMs return to IDLE the next cycle and tx_serial=1. The in-flight frame is dropped; no rx_valid.
- Frame bit count: N = 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP.
  - Handshake: tx_valid && tx_ready latches tx_data in cycle T.
  - Start bit (0) drives cycles T+1..T+CLKS_PER_BIT; each subsequent bit lasts exactly CLKS_PER_BIT cycles.
  - Parity bit: even = XOR of data; odd = its inverse.
  - tx_ready=1 in IDLE and in the final clk of the last stop bit only, so a held tx_valid gives back-to-back frames with no idle gap.
  - tx_busy=1 from T+1 through T+N*CLKS_PER_BIT.
  - tx_data changes while busy are ignored.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE; all decisions use the synchronised line (rxs).
  - IDLE: first cycle rxs=0 enters START; bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, rxs must be 0, otherwise it is a glitch and the FSM returns to IDLE with no output.
  - DATA/PARITY/STOP: sample every CLKS_PER_BIT cycles at bit centre; data shifted LSB first.
  - Every stop bit is checked; any low stop bit sets frame error.
  - Output: at the last stop-bit sample, rx_valid pulses for 1 cycle, rx_data updates, and both error flags are valid. The flags are 0 whenever rx_valid=0. rx_data holds until the next rx_valid.
  - Latency: first low cycle on rx_serial at E -> rx_valid at E + SYNC_STAGES + CLKS_PER_BIT/2 + (N-1)*CLKS_PER_BIT.
  - Break handling: after a frame error, RX waits for rxs=1 before re-arming, so a held-low line yields exactly one rx_valid with rx_frame_err=1.
- Counters: baud counter width $clog2(CLKS_PER_BIT); bit counter width $clog2(N+1). No wrap occurs inside a frame.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the synchroniser input is the internal TX line instead of rx_serial, and tx_serial is forced to 1.
  - loopback may change only while tx_busy=0 and RX is IDLE.
- Undefined: port absent; RX always takes rx_serial.

Test Plan:
- DATA_WIDTH=8, even parity, 1 stop, CLKS_PER_BIT=16; send 0xA5 on tx_serial looped to rx_serial.
  -> tx_serial bits 0,1,0,1,0,0,1,0,1,0(parity),1.
  -> tx_busy for 176 cycles; rx_valid at E+171 with rx_data=0xA5 and both error flags 0.
- PARITY_MODE=2, STOP_BITS=2; send 0x00 -> parity bit 1, frame 12*16=192 cycles, rx_data=0x00, no errors.
- Hold tx_valid with 0x55 then 0x3C -> second start bit begins the cycle after the first frame's last stop clk; two rx_valid pulses 176 cycles apart, correct data.
- Drive rx_serial with the 0xA5 frame but flipped parity -> rx_valid with rx_parity_err=1, rx_data=0xA5.
  - Same with stop bit 0 -> rx_frame_err=1.
  - Then hold the line low 500 cycles -> no further rx_valid until the line returns high.
- 4-cycle low glitch on idle rx_serial -> no rx_valid, RX back in IDLE.
- Assert reset at cycle 60 of a TX frame -> tx_serial=1 and tx_ready=1 the next cycle; the receiver emits no rx_valid.
